// File: rtl/cmac_rx_pkt_fifo_if.sv
// AXI4-Stream bundle shared by the CMAC RX side and the kernel side of cmac_rx_pkt_fifo.
// The master drives the beat and the slave returns tready.
interface cmac_rx_pkt_fifo_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic                    tuser;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/cmac_rx_pkt_fifo.sv
// Packet-mode store-and-forward FIFO from the CMAC RX stream (no backpressure) to the kernel RX stream.
// Optional statistics counters are enabled with `define CMAC_RX_PKT_FIFO_STATS_EN.
module cmac_rx_pkt_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      rstn,
  cmac_rx_pkt_fifo_if.slave         s_axis,
  cmac_rx_pkt_fifo_if.master        m_axis,
  output logic [31:0]               pkt_count,
  output logic [31:0]               drop_err_count,
  output logic [31:0]               drop_ovf_count
);

  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = DATA_WIDTH + KEEP_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_e;

  wr_state_e          state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]   wr_commit, wr_commit_nxt;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               ram_we;
  logic               inc_pkt, inc_err, inc_ovf;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] ram_q;
  logic               ram_q_valid;
  logic               data_avail;
  logic               out_ready;
  logic               rd_en;

  // Every CMAC beat is accepted; the kernel side never carries an error flag.
  assign s_axis.tready = 1'b1;
  assign m_axis.tuser  = 1'b0;

  assign full = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RECV: begin
        if (s_axis.tvalid) begin
          if (s_axis.tlast)
            state_nxt = IDLE;
          else if (full)
            state_nxt = DROP;
          else
            state_nxt = RECV;
        end
      end
      DROP: begin
        if (s_axis.tvalid && s_axis.tlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beats are written speculatively; a bad or overflowing packet rewinds wr_ptr to the last commit.
  always_comb begin
    ram_we        = 1'b0;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    inc_pkt       = 1'b0;
    inc_err       = 1'b0;
    inc_ovf       = 1'b0;
    if ((state == IDLE || state == RECV) && s_axis.tvalid) begin
      if (full) begin
        wr_ptr_nxt = wr_commit;
        inc_ovf    = 1'b1;
      end else begin
        ram_we = 1'b1;
        if (s_axis.tlast && s_axis.tuser) begin
          wr_ptr_nxt = wr_commit;
          inc_err    = 1'b1;
        end else if (s_axis.tlast) begin
          wr_ptr_nxt    = wr_ptr + PTR_W'(1);
          wr_commit_nxt = wr_ptr + PTR_W'(1);
          inc_pkt       = 1'b1;
        end else begin
          wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    if (rd_en)
      ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  // Two-stage read pipeline: RAM output register, then the AXIS output register.
  assign data_avail = (rd_ptr != wr_commit);
  assign out_ready  = !m_axis.tvalid || m_axis.tready;
  assign rd_en      = data_avail && (!ram_q_valid || out_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr      <= '0;
      ram_q_valid <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        ram_q_valid <= 1'b1;
      end else if (out_ready) begin
        ram_q_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tkeep  <= '0;
      m_axis.tdata  <= '0;
    end else if (out_ready) begin
      m_axis.tvalid <= ram_q_valid;
      if (ram_q_valid)
        {m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= ram_q;
    end
  end

`ifdef CMAC_RX_PKT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_count      <= '0;
      drop_err_count <= '0;
      drop_ovf_count <= '0;
    end else begin
      if (inc_pkt && pkt_count != '1)
        pkt_count <= pkt_count + 32'd1;
      if (inc_err && drop_err_count != '1)
        drop_err_count <= drop_err_count + 32'd1;
      if (inc_ovf && drop_ovf_count != '1)
        drop_ovf_count <= drop_ovf_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats   = inc_pkt ^ inc_err ^ inc_ovf;
  assign pkt_count      = '0;
  assign drop_err_count = '0;
  assign drop_ovf_count = '0;
`endif

endmodule
